burst_bus_master: RTL and testbench
===================================

BURST_BUS_MASTER -- requirements
Module: burst_bus_master

Interface
REQ-001 Parameter ADDR_W, default 4, address width in bits.
REQ-002 Parameter DATA_W, default 32, data width in bits.
REQ-003 Parameter LEN_W, default 4, burst-length width in beats.
REQ-004 Parameter MAX_OUT, default 2, maximum outstanding read bursts (>=1).
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid  in  1  host command present.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-009 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-010 cmd_address  in  ADDR_W  burst start address.
REQ-011 cmd_length  in  LEN_W  beats in burst; 0 is illegal.
REQ-012 wdata_valid / wdata_ready / wdata  in / out / DATA_W  write-beat stream.
REQ-013 rsp_valid / rsp_data / rsp_last  out / out / out  read-beat stream, 1 / DATA_W / 1 bits.
REQ-014 bus_wr, bus_rd  out  1  bus write / read request.
REQ-015 bus_address / bus_length / bus_wdata  out  ADDR_W / LEN_W / DATA_W.
REQ-016 bus_ready  in  1  slave accepts the current request or write beat.
REQ-017 bus_rddatavalid / bus_rdata  in / in  1 / DATA_W  read-return beat.
REQ-018 busy  out  1  FSM not IDLE or any read outstanding.
REQ-019 err  out  1  sticky error flag.

Function
REQ-020 FSM states SHALL be IDLE, RD_REQ and WR_BURST.
REQ-021 cmd_ready SHALL be 1 only in IDLE and, for reads, only when outstanding count < MAX_OUT; for writes, regardless of outstanding reads.
REQ-022 An accepted command with cmd_length==0 SHALL be dropped, set err, and leave the FSM in IDLE.
REQ-023 Read accepted in cycle N: bus_rd=1 with registered address and length from cycle N+1 (RD_REQ), held stable until bus_ready=1.
REQ-024 On bus_rd && bus_ready, bus_length SHALL be pushed into a MAX_OUT-deep length FIFO, and the FSM SHALL return to IDLE.
REQ-025 Write accepted: FSM SHALL enter WR_BURST, with bus_address and bus_length held for the whole burst.
REQ-026 WR_BURST SHALL use a one-entry write buffer; bus_wr=buffer valid, bus_wdata=buffer data; wdata_ready = !buffer valid || bus_ready.
REQ-027 A write beat SHALL complete on bus_wr && bus_ready; after beat cmd_length completes, bus_wr SHALL deassert and the FSM SHALL return to IDLE in the next cycle; wdata_ready SHALL be 0 once all beats are buffered.
REQ-028 bus_rddatavalid in cycle M SHALL produce rsp_valid=1 with rsp_data=bus_rdata in cycle M+1; there is no backpressure.
REQ-029 A beat counter SHALL count returned beats against the FIFO head length; on the last beat, rsp_last=1, the head is popped and the counter is cleared.
REQ-030 A pop and a push in the same cycle SHALL leave the outstanding count unchanged, and both SHALL take effect.
REQ-031 bus_rddatavalid with no read outstanding SHALL be ignored (no rsp_valid) and SHALL set err.
REQ-032 Read returns SHALL be processed in every FSM state, including during WR_BURST.
REQ-033 Counters SHALL be LEN_W wide with no wrap; maximum burst = 2^LEN_W-1 beats.
REQ-034 bus_rd and bus_wr SHALL never both be 1.

Reset
REQ-035 While reset=0: FSM=IDLE; FIFO, counters and write buffer cleared; all outputs 0, including err and busy.
REQ-036 Reset asserted mid-burst SHALL abandon all bursts; beats returning after release SHALL follow REQ-031.

Verification
REQ-037 Read addr 4, len 1, bus_ready low 2 cycles then high -> bus_rd held 3 cycles with address 4 / length 1; rddatavalid one cycle later -> one rsp beat with rsp_last=1.
REQ-038 Read addr 5, len 3 back-to-back with read addr 8, len 2, MAX_OUT=2 -> both issued, third read stalls cmd_ready=0; 5 returned beats -> rsp_last on beats 3 and 5.
REQ-039 Write addr 2, len 4, wdata gaps, bus_ready toggling -> exactly 4 bus_wr&&bus_ready beats in order, address/length constant, then IDLE.
REQ-040 bus_rddatavalid pulse when idle -> no rsp_valid, err=1 sticky until reset.
REQ-041 cmd_length=0 -> no bus activity, err=1.
REQ-042 Reset asserted during a 3-beat read after the first beat -> outputs 0 immediately; remaining 2 beats after release -> err=1, no rsp_valid.

Source files
------------

// File: rtl/burst_bus_master_if.sv
// Host command/write/response streams and the burst bus, bundled for burst_bus_master.
// master = the burst master's view; slave = host plus bus slave.
interface burst_bus_master_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [LEN_W-1:0]  cmd_length;

    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;

    logic              bus_wr;
    logic              bus_rd;
    logic [ADDR_W-1:0] bus_address;
    logic [LEN_W-1:0]  bus_length;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ready;
    logic              bus_rddatavalid;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_length,
        input  wdata_valid, wdata,
        input  bus_ready, bus_rddatavalid, bus_rdata,
        output cmd_ready, wdata_ready,
        output rsp_valid, rsp_data, rsp_last,
        output bus_wr, bus_rd, bus_address, bus_length, bus_wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_length,
        output wdata_valid, wdata,
        output bus_ready, bus_rddatavalid, bus_rdata,
        input  cmd_ready, wdata_ready,
        input  rsp_valid, rsp_data, rsp_last,
        input  bus_wr, bus_rd, bus_address, bus_length, bus_wdata
    );
endinterface

// File: rtl/burst_bus_master.sv
// Burst bus master: issues read/write bursts from host commands, tracks up to
// MAX_OUT outstanding read bursts and returns read beats with a last marker.
module burst_bus_master #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    burst_bus_master_if.master     bus,
    output logic                   busy,
    output logic                   err
);
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, RD_REQ, WR_BURST} state_t;

    state_t            state_q, state_d;
    logic              run_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;

    logic              buf_valid_q;
    logic [DATA_W-1:0] buf_data_q;
    logic [LEN_W-1:0]  wr_acc_q;
    logic [LEN_W-1:0]  wr_done_q;

    logic [LEN_W-1:0]  fifo_q [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  out_cnt_q;
    logic [LEN_W-1:0]  beat_q;

    logic              rsp_valid_q, rsp_last_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              err_q;

    logic cmd_ready_c, wdata_ready_c;
    logic cmd_fire, zero_len, in_wr, wr_take, wr_beat, wr_last;
    logic rd_fire, ret_ok, ret_last, push, pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // run_q keeps cmd_ready low while reset is held
    assign cmd_ready_c   = run_q && (state_q == IDLE) &&
                           (bus.cmd_write || (out_cnt_q < CNT_W'(MAX_OUT)));
    assign cmd_fire      = bus.cmd_valid && cmd_ready_c;
    assign zero_len      = (bus.cmd_length == '0);
    assign in_wr         = (state_q == WR_BURST);
    assign wdata_ready_c = in_wr && (wr_acc_q != len_q) && (!buf_valid_q || bus.bus_ready);
    assign wr_take       = bus.wdata_valid && wdata_ready_c;
    assign wr_beat       = in_wr && buf_valid_q && bus.bus_ready;
    assign wr_last       = ((wr_done_q + LEN_W'(1)) == len_q);
    assign rd_fire       = (state_q == RD_REQ) && bus.bus_ready;
    assign ret_ok        = bus.bus_rddatavalid && (out_cnt_q != '0);
    assign ret_last      = ((beat_q + LEN_W'(1)) == fifo_q[rd_ptr_q]);
    assign push          = rd_fire;
    assign pop           = ret_ok && ret_last;

    assign bus.cmd_ready   = cmd_ready_c;
    assign bus.wdata_ready = wdata_ready_c;
    assign bus.bus_address = addr_q;
    assign bus.bus_length  = len_q;
    assign bus.bus_wdata   = buf_data_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_last    = rsp_last_q;
    assign busy            = (state_q != IDLE) || (out_cnt_q != '0);
    assign err             = err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        bus.bus_rd = 1'b0;
        bus.bus_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_fire && !zero_len) begin
                    state_d = bus.cmd_write ? WR_BURST : RD_REQ;
                end
            end
            RD_REQ: begin
                bus.bus_rd = 1'b1;
                if (bus.bus_ready) begin
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                bus.bus_wr = buf_valid_q;
                if (wr_beat && wr_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst address/length captured on acceptance, held for the whole burst
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            len_q  <= '0;
        end else if (cmd_fire && !zero_len) begin
            addr_q <= bus.cmd_address;
            len_q  <= bus.cmd_length;
        end
    end

    // One-entry write buffer; a beat may be refilled in the cycle it drains
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            wr_acc_q    <= '0;
            wr_done_q   <= '0;
        end else if (cmd_fire) begin
            buf_valid_q <= 1'b0;
            wr_acc_q    <= '0;
            wr_done_q   <= '0;
        end else begin
            if (wr_take) begin
                buf_data_q  <= bus.wdata;
                wr_acc_q    <= wr_acc_q + LEN_W'(1);
                buf_valid_q <= 1'b1;
            end else if (wr_beat) begin
                buf_valid_q <= 1'b0;
            end
            if (wr_beat) begin
                wr_done_q <= wr_done_q + LEN_W'(1);
            end
        end
    end

    // Outstanding read lengths, oldest at rd_ptr_q
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(MAX_OUT); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= len_q;
                wr_ptr_q         <= ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   out_cnt_q <= out_cnt_q + CNT_W'(1);
                2'b01:   out_cnt_q <= out_cnt_q - CNT_W'(1);
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    // Read return path; stray beats with nothing outstanding only raise err
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= ret_ok;
            rsp_last_q  <= pop;
            if (ret_ok) begin
                rsp_data_q <= bus.bus_rdata;
                beat_q     <= pop ? '0 : beat_q + LEN_W'(1);
            end
            if ((cmd_fire && zero_len) || (bus.bus_rddatavalid && (out_cnt_q == '0))) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_burst_bus_master.sv
// Directed self-checking bench for burst_bus_master: reads, outstanding limit,
// write burst with gaps/backpressure, stray returns, zero length, mid-burst reset.
module tb_burst_bus_master;
    logic clock;
    logic reset;
    logic busy;
    logic err;
    int   checks;
    int   errors;

    burst_bus_master_if #(.ADDR_W(4), .DATA_W(32), .LEN_W(4)) bif ();

    burst_bus_master #(.ADDR_W(4), .DATA_W(32), .LEN_W(4), .MAX_OUT(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif.master),
        .busy  (busy),
        .err   (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rsp_valid"}, 32'(bif.rsp_valid), 32'd0);
        chk({tag, "_bus_rd"}, 32'(bif.bus_rd), 32'd0);
        chk({tag, "_bus_wr"}, 32'(bif.bus_wr), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(bif.cmd_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_quiet("rst");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic send_cmd(input logic wr, input logic [3:0] addr, input logic [3:0] len);
        bif.cmd_valid   = 1'b1;
        bif.cmd_write   = wr;
        bif.cmd_address = addr;
        bif.cmd_length  = len;
    endtask

    initial begin
        logic [15:0] wv_pat;
        logic [15:0] br_pat;
        int sent;
        int done;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_address = '0; bif.cmd_length = '0;
        bif.wdata_valid = 1'b0; bif.wdata = '0;
        bif.bus_ready = 1'b0; bif.bus_rddatavalid = 1'b0; bif.bus_rdata = '0;
        wv_pat = 16'b1111_1110_1101_1101;
        br_pat = 16'b1111_0101_1011_0110;

        // Reset state
        @(negedge clock);
        chk_quiet("init");
        chk("init_wdata_ready", 32'(bif.wdata_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Read addr 4 len 1, bus_ready low for two cycles
        send_cmd(1'b0, 4'd4, 4'd1);
        #1;
        chk("r1_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        @(negedge clock);
        bif.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bif.bus_ready = (i == 2);
            #1;
            chk("r1_bus_rd", 32'(bif.bus_rd), 32'd1);
            chk("r1_addr", 32'(bif.bus_address), 32'd4);
            chk("r1_len", 32'(bif.bus_length), 32'd1);
            @(negedge clock);
        end
        bif.bus_ready = 1'b0;
        #1;
        chk("r1_rd_drop", 32'(bif.bus_rd), 32'd0);
        chk("r1_busy_out", 32'(busy), 32'd1);
        bif.bus_rddatavalid = 1'b1;
        bif.bus_rdata = 32'hA5A5_0001;
        @(negedge clock);
        bif.bus_rddatavalid = 1'b0;
        chk("r1_rsp_valid", 32'(bif.rsp_valid), 32'd1);
        chk("r1_rsp_data", bif.rsp_data, 32'hA5A5_0001);
        chk("r1_rsp_last", 32'(bif.rsp_last), 32'd1);
        @(negedge clock);
        chk("r1_rsp_end", 32'(bif.rsp_valid), 32'd0);
        chk("r1_idle", 32'(busy), 32'd0);
        chk("r1_err", 32'(err), 32'd0);

        // Two back-to-back reads fill the outstanding limit
        send_cmd(1'b0, 4'd5, 4'd3);
        bif.bus_ready = 1'b1;
        @(negedge clock);
        chk("r2_addr", 32'(bif.bus_address), 32'd5);
        chk("r2_len", 32'(bif.bus_length), 32'd3);
        send_cmd(1'b0, 4'd8, 4'd2);
        @(negedge clock);
        #1;
        chk("r3_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        @(negedge clock);
        chk("r3_bus_rd", 32'(bif.bus_rd), 32'd1);
        chk("r3_addr", 32'(bif.bus_address), 32'd8);
        chk("r3_len", 32'(bif.bus_length), 32'd2);
        send_cmd(1'b0, 4'd1, 4'd1);
        @(negedge clock);
        #1;
        chk("r4_stall", 32'(bif.cmd_ready), 32'd0);
        chk("r4_no_rd", 32'(bif.bus_rd), 32'd0);
        bif.cmd_write = 1'b1;
        #1;
        chk("r4_write_ok", 32'(bif.cmd_ready), 32'd1);
        bif.cmd_write = 1'b0;
        bif.cmd_valid = 1'b0;
        bif.bus_ready = 1'b0;
        @(negedge clock);
        chk("r4_still_stalled", 32'(bif.bus_rd), 32'd0);
        for (int i = 0; i < 5; i++) begin
            bif.bus_rddatavalid = 1'b1;
            bif.bus_rdata = 32'h0000_0100 + 32'(i);
            @(negedge clock);
            bif.bus_rddatavalid = 1'b0;
            chk("r5_rsp_valid", 32'(bif.rsp_valid), 32'd1);
            chk("r5_rsp_data", bif.rsp_data, 32'h0000_0100 + 32'(i));
            chk("r5_rsp_last", 32'(bif.rsp_last), ((i == 2) || (i == 4)) ? 32'd1 : 32'd0);
        end
        @(negedge clock);
        chk("r5_done", 32'(bif.rsp_valid), 32'd0);
        chk("r5_idle", 32'(busy), 32'd0);

        // Write addr 2 len 4 with data gaps and toggling bus_ready
        send_cmd(1'b1, 4'd2, 4'd4);
        #1;
        chk("w_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        @(negedge clock);
        bif.cmd_valid = 1'b0;
        bif.cmd_write = 1'b0;
        sent = 0;
        done = 0;
        for (int c = 0; c < 40 && done < 4; c++) begin
            bif.wdata_valid = (sent < 4) && wv_pat[c % 16];
            bif.wdata = 32'hD000_0000 + 32'(sent);
            bif.bus_ready = br_pat[c % 16];
            #1;
            chk("w_no_rd", 32'(bif.bus_rd), 32'd0);
            if (sent == 4) chk("w_ready_full", 32'(bif.wdata_ready), 32'd0);
            if (bif.bus_wr && bif.bus_ready) begin
                chk("w_data", bif.bus_wdata, 32'hD000_0000 + 32'(done));
                chk("w_addr", 32'(bif.bus_address), 32'd2);
                chk("w_len", 32'(bif.bus_length), 32'd4);
                done++;
            end
            if (bif.wdata_valid && bif.wdata_ready) sent++;
            @(negedge clock);
        end
        chk("w_beats", 32'(done), 32'd4);
        bif.wdata_valid = 1'b0;
        bif.bus_ready = 1'b0;
        #1;
        chk("w_wr_off", 32'(bif.bus_wr), 32'd0);
        chk("w_idle", 32'(busy), 32'd0);
        chk("w_err", 32'(err), 32'd0);

        // Stray return when idle
        @(negedge clock);
        bif.bus_rddatavalid = 1'b1;
        bif.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        bif.bus_rddatavalid = 1'b0;
        chk("stray_rsp", 32'(bif.rsp_valid), 32'd0);
        chk("stray_err", 32'(err), 32'd1);
        repeat (3) @(negedge clock);
        chk("stray_sticky", 32'(err), 32'd1);

        // Zero-length command
        do_reset();
        send_cmd(1'b0, 4'd7, 4'd0);
        #1;
        chk("z_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        @(negedge clock);
        bif.cmd_valid = 1'b0;
        chk("z_no_rd", 32'(bif.bus_rd), 32'd0);
        chk("z_busy", 32'(busy), 32'd0);
        chk("z_err", 32'(err), 32'd1);
        @(negedge clock);
        chk("z_no_rd2", 32'(bif.bus_rd), 32'd0);
        chk("z_no_wr2", 32'(bif.bus_wr), 32'd0);

        // Reset during a 3-beat read after its first beat
        do_reset();
        send_cmd(1'b0, 4'd3, 4'd3);
        bif.bus_ready = 1'b1;
        @(negedge clock);
        bif.cmd_valid = 1'b0;
        chk("m_bus_rd", 32'(bif.bus_rd), 32'd1);
        @(negedge clock);
        bif.bus_ready = 1'b0;
        bif.bus_rddatavalid = 1'b1;
        bif.bus_rdata = 32'h1234_0000;
        @(negedge clock);
        bif.bus_rddatavalid = 1'b0;
        chk("m_beat1", 32'(bif.rsp_valid), 32'd1);
        chk("m_beat1_last", 32'(bif.rsp_last), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk_quiet("m_rst");
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bif.bus_rddatavalid = 1'b1;
            bif.bus_rdata = 32'h1234_0001 + 32'(i);
            @(negedge clock);
            chk("m_late_rsp", 32'(bif.rsp_valid), 32'd0);
        end
        bif.bus_rddatavalid = 1'b0;
        chk("m_late_err", 32'(err), 32'd1);
        chk("m_late_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
